match_controller: RTL and testbench

Frame-rate game-flow controller directly downstream of the bullet hit detector. It consumes the per-frame hit levels and converts them into single-count scoring events. It then sequences the match through idle, play, respawn-freeze and game-over, and owns the authoritative scores, winner flags and armor lifetime that the renderer and player/bullet movers consume.

---
 rtl/match_controller.sv | 179 +++++++++++++++++
 tb/tb_match_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Game-flow controller: converts hit levels into scoring events and sequences IDLE/PLAY/RESPAWN/GAME_OVER.
// All outputs registered; an event sampled at edge k is reflected at edge k. Optional armor logic via `MATCH_ARMOR_EN.
module match_controller #(
    parameter int WIN_SCORE      = 5,
    parameter int RESPAWN_FRAMES = 120,
    parameter int ARMOR_HITS     = 3
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       player_1_hit,
    input  logic       player_2_hit,
    input  logic       armor_hit,
    output logic [4:0] player_1_score,
    output logic [4:0] player_2_score,
    output logic [1:0] game_state,
    output logic       freeze,
    output logic       respawn,
    output logic       p1_wins,
    output logic       p2_wins,
    output logic       armor_enabled
);

    localparam int CW = $clog2(RESPAWN_FRAMES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      p1_score_q, p1_score_d;
    logic [4:0]      p2_score_q, p2_score_d;
    logic            p1_wins_q, p1_wins_d;
    logic            p2_wins_q, p2_wins_d;
    logic            freeze_q, freeze_d;
    logic            respawn_q, respawn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_prev_q, p1_prev_q, p2_prev_q;

    logic start_ev, p1_scores, p2_scores, match_start;

    assign start_ev  = start & ~start_prev_q;
    // player_2_hit means P1's bullet landed, so it scores for P1
    assign p1_scores = player_2_hit & ~p2_prev_q;
    assign p2_scores = player_1_hit & ~p1_prev_q;

    always_comb begin
        state_d     = state_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        p1_wins_d   = p1_wins_q;
        p2_wins_d   = p2_wins_q;
        cnt_d       = cnt_q;
        respawn_d   = 1'b0;
        match_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_ev) begin
                    match_start = 1'b1;
                    p1_score_d  = 5'd0;
                    p2_score_d  = 5'd0;
                    p1_wins_d   = 1'b0;
                    p2_wins_d   = 1'b0;
                    cnt_d       = '0;
                    respawn_d   = 1'b1;
                    state_d     = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (p1_scores || p2_scores) begin
                    p1_score_d = p1_score_q + {4'd0, p1_scores};
                    p2_score_d = p2_score_q + {4'd0, p2_scores};
                    if (p1_score_d == 5'(WIN_SCORE) || p2_score_d == 5'(WIN_SCORE)) begin
                        p1_wins_d = (p1_score_d == 5'(WIN_SCORE));
                        p2_wins_d = (p2_score_d == 5'(WIN_SCORE));
                        state_d   = ST_OVER;
                    end else begin
                        cnt_d     = CW'(RESPAWN_FRAMES - 1);
                        respawn_d = 1'b1;
                        state_d   = ST_RESPAWN;
                    end
                end
            end
            ST_RESPAWN: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            p1_score_q   <= 5'd0;
            p2_score_q   <= 5'd0;
            p1_wins_q    <= 1'b0;
            p2_wins_q    <= 1'b0;
            freeze_q     <= 1'b1;
            respawn_q    <= 1'b0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            p1_prev_q    <= 1'b0;
            p2_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            p1_wins_q    <= p1_wins_d;
            p2_wins_q    <= p2_wins_d;
            freeze_q     <= freeze_d;
            respawn_q    <= respawn_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start;
            p1_prev_q    <= player_1_hit;
            p2_prev_q    <= player_2_hit;
        end
    end

`ifdef MATCH_ARMOR_EN
    logic       armor_prev_q;
    logic [3:0] armor_cnt_q, armor_cnt_d;
    logic       armor_en_q, armor_en_d;
    logic       armor_ev;

    assign armor_ev = armor_hit & ~armor_prev_q;

    always_comb begin
        armor_cnt_d = armor_cnt_q;
        armor_en_d  = armor_en_q;
        if (match_start) begin
            armor_cnt_d = 4'd0;
            armor_en_d  = 1'b1;
        end else if (state_q == ST_PLAY && armor_ev && armor_en_q) begin
            armor_cnt_d = armor_cnt_q + 4'd1;
            // once removed, armor stays gone until the next match start
            if (armor_cnt_d == 4'(ARMOR_HITS)) begin
                armor_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            armor_prev_q <= 1'b0;
            armor_cnt_q  <= 4'd0;
            armor_en_q   <= 1'b0;
        end else begin
            armor_prev_q <= armor_hit;
            armor_cnt_q  <= armor_cnt_d;
            armor_en_q   <= armor_en_d;
        end
    end

    assign armor_enabled = armor_en_q;
`else
    logic unused_armor_hit;
    logic unused_match_start;
    assign unused_armor_hit   = armor_hit;
    assign unused_match_start = match_start;
    assign armor_enabled      = 1'b0;
`endif

    assign player_1_score = p1_score_q;
    assign player_2_score = p2_score_q;
    assign game_state     = state_q;
    assign freeze         = freeze_q;
    assign respawn        = respawn_q;
    assign p1_wins        = p1_wins_q;
    assign p2_wins        = p2_wins_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed scenarios then randomized levels, checked against a frame-level game model.
module tb_match_controller;

    localparam int WIN = 5;
    localparam int RF  = 120;
    localparam int AH  = 3;
`ifdef MATCH_ARMOR_EN
    localparam bit ARM_ON = 1'b1;
`else
    localparam bit ARM_ON = 1'b0;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       start = 1'b0, player_1_hit = 1'b0, player_2_hit = 1'b0, armor_hit = 1'b0;
    logic [4:0] player_1_score, player_2_score;
    logic [1:0] game_state;
    logic       freeze, respawn, p1_wins, p2_wins, armor_enabled;

    int total = 0;
    int bad   = 0;

    match_controller #(.WIN_SCORE(WIN), .RESPAWN_FRAMES(RF), .ARMOR_HITS(AH)) dut (
        .frame_clk      (frame_clk),
        .Reset_n        (Reset_n),
        .start          (start),
        .player_1_hit   (player_1_hit),
        .player_2_hit   (player_2_hit),
        .armor_hit      (armor_hit),
        .player_1_score (player_1_score),
        .player_2_score (player_2_score),
        .game_state     (game_state),
        .freeze         (freeze),
        .respawn        (respawn),
        .p1_wins        (p1_wins),
        .p2_wins        (p2_wins),
        .armor_enabled  (armor_enabled)
    );

    always #5 frame_clk = ~frame_clk;

    // game model: 0 idle, 1 play, 2 respawn, 3 over
    int m_state, m_s1, m_s2, m_left, m_armor_cnt;
    bit m_w1, m_w2, m_resp, m_arm;
    bit pv_st, pv_p1, pv_p2, pv_ar;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_s1 = 0; m_s2 = 0; m_left = 0; m_armor_cnt = 0;
        m_w1 = 0; m_w2 = 0; m_resp = 0; m_arm = 0;
        pv_st = 0; pv_p1 = 0; pv_p2 = 0; pv_ar = 0;
    endtask

    task automatic model_step(input bit st, input bit p1, input bit p2, input bit ar);
        bit e_st, e_s1, e_s2, e_ar;
        e_st = st && !pv_st;
        e_s1 = p2 && !pv_p2;
        e_s2 = p1 && !pv_p1;
        e_ar = ar && !pv_ar && ARM_ON;
        m_resp = 0;
        case (m_state)
            0, 3: if (e_st) begin
                m_s1 = 0; m_s2 = 0; m_w1 = 0; m_w2 = 0;
                m_armor_cnt = 0; m_arm = ARM_ON; m_resp = 1; m_state = 1;
            end
            1: begin
                if (e_ar && m_arm) begin
                    m_armor_cnt++;
                    if (m_armor_cnt == AH) m_arm = 0;
                end
                if (e_s1 || e_s2) begin
                    m_s1 += int'(e_s1);
                    m_s2 += int'(e_s2);
                    if (m_s1 == WIN || m_s2 == WIN) begin
                        m_w1 = (m_s1 == WIN); m_w2 = (m_s2 == WIN); m_state = 3;
                    end else begin
                        m_left = RF; m_resp = 1; m_state = 2;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_state = 1;
            end
        endcase
        pv_st = st; pv_p1 = p1; pv_p2 = p2; pv_ar = ar;
    endtask

    task automatic check_all();
        chk("state",   int'(game_state),     m_state);
        chk("p1_score", int'(player_1_score), m_s1);
        chk("p2_score", int'(player_2_score), m_s2);
        chk("freeze",  int'(freeze),         int'(m_state != 1));
        chk("respawn", int'(respawn),        int'(m_resp));
        chk("wins",    int'({p1_wins, p2_wins}), int'({m_w1, m_w2}));
        chk("armor",   int'(armor_enabled),  int'(m_arm));
    endtask

    // called at a negedge; returns at the following negedge
    task automatic cycle(input bit st, input bit p1, input bit p2, input bit ar);
        start = st; player_1_hit = p1; player_2_hit = p2; armor_hit = ar;
        @(posedge frame_clk);
        model_step(st, p1, p2, ar);
        @(negedge frame_clk);
        check_all();
    endtask

    task automatic do_reset();
        #2 Reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge frame_clk);
        check_all();
        Reset_n = 1'b1;
    endtask

    task automatic wait_play();
        int n = 0;
        while (game_state != 2'd1 && n < 300) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        if (n >= 300) chk("wait_play_timeout", 0, 1);
    endtask

    initial begin
        int frames;
        bit l1, l2, la;
        model_reset();
        @(negedge frame_clk);
        do_reset();

        // start, then P1 scores with the hit level held 3 frames
        cycle(1, 0, 0, 0);
        chk("start_resp", int'(respawn), 1);
        cycle(0, 0, 1, 0);
        chk("first_score", int'(player_1_score), 1);
        chk("first_state", int'(game_state), 2);
        frames = 1;
        cycle(0, 0, 1, 0); frames += int'(freeze);
        cycle(0, 0, 1, 0); frames += int'(freeze);
        while (freeze && frames < 300) begin
            cycle(0, 0, 0, 0);
            frames += int'(freeze);
        end
        chk("respawn_len", frames, RF);

        // climb to 4/4 with one P2 score and three trades, then a trade to 5/5
        cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); wait_play();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 0); cycle(0, 0, 0, 0); wait_play();
        end
        chk("pre_draw", int'({player_1_score, player_2_score}), int'({5'd4, 5'd4}));
        cycle(0, 1, 1, 0);
        chk("draw_state", int'(game_state), 3);
        chk("draw_wins", int'({p1_wins, p2_wins}), 3);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("over_hold", int'(player_1_score), WIN);

        // restart from game over
        cycle(1, 0, 0, 0);
        chk("restart", int'({player_1_score, player_2_score, p1_wins, p2_wins}), 0);
        chk("restart_state", int'(game_state), 1);
        chk("restart_resp", int'(respawn), 1);

        // P1 hit pulsed during respawn and held across respawn->play
        cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
        frames = 0;
        while (game_state != 2'd1 && frames < 300) begin
            cycle(0, 1, 0, 0); frames++;
        end
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        chk("no_double", int'(player_2_score), 0);
        cycle(0, 0, 0, 0);

        // three armor edges in play
        for (int i = 0; i < AH; i++) begin
            cycle(0, 0, 0, 1);
            chk("armor_edge", int'(armor_enabled), (i < AH - 1) ? int'(ARM_ON) : 0);
            cycle(0, 0, 0, 0);
        end

        // async reset in respawn with scores 2/3
        do_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 1, 0); cycle(0, 0, 0, 0); wait_play();
        end
        cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        chk("pre_reset", int'({player_1_score, player_2_score, game_state}), int'({5'd2, 5'd3, 2'd2}));
        do_reset();

        // randomized levels
        l1 = 0; l2 = 0; la = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 2) == 0) l1 = !l1;
            if ($urandom_range(0, 2) == 0) l2 = !l2;
            if ($urandom_range(0, 1) == 0) la = !la;
            cycle(($urandom_range(0, 15) == 0), l1, l2, la);
            if ($urandom_range(0, 1499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
